piezo_sequencer: RTL
====================

Name: piezo_sequencer

Overview:
- Tone-sequencing controller that sits between the CPU-side MMIO bus and the existing piezo driver.
- Software enqueues notes; each note is a 24-bit half-period compare value plus a 16-bit duration in ticks.
- The block plays the queued notes back-to-back by issuing driver writes, times each note, and silences the driver when the queue drains or on abort.
- This frees the CPU from busy-waiting on melodies.

Parameters:
- DEPTH, 8: note queue entries; must be a power of 2 and at least 2.
- TICK_DIV, 100000: clock cycles per duration tick (1 ms at 100 MHz).
- DUR_W, 16: duration field width.

Ports:
- clock  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-low reset.
- in_valid  in  1  enqueue request.
- in_period  in  24  half-period compare value; 0 = rest (silent note).
- in_duration  in  DUR_W  note length in ticks; 0 is treated as 1.
- in_ready  out  1  queue not full; a push occurs iff in_valid & in_ready.
- abort  in  1  flush the queue and silence immediately.
- drv_data  out  25  to driver data; [24] = enable, [23:0] = compare.
- drv_write  out  1  single-cycle write strobe to the driver.
- drv_ready  in  1  driver acknowledge (driver Ready, one cycle after its Write).
- busy  out  1  high whenever state != IDLE.
- queue_count  out  $clog2(DEPTH)+1  number of entries held.
- done  out  1  one-cycle pulse when playback ends, whether by drain or by abort.

Behaviour:
- Reset (reset==0 at a clock edge):
  - Queue empty; state IDLE.
  - drv_write=0, drv_data=0, busy=0, done=0, queue_count=0, in_ready=0.
  - in_ready rises on the first cycle after reset is released.
- States: IDLE, LOAD, ACK, PLAY, STOP, STOP_ACK.
- IDLE: if queue is non-empty, pop the head into note registers and go to LOAD.
- LOAD, one cycle:
  - drv_write=1.
  - drv_data = {1'b1, period} if period != 0, else 25'h0.
  - Go to ACK.
- ACK: wait for drv_ready. No timeout; only abort or reset exits. On drv_ready, clear the tick prescaler and tick counter, then go to PLAY.
- PLAY:
  - Prescaler counts 0..TICK_DIV-1; on wrap, the tick counter increments.
  - When tick counter == max(duration,1), the note is done:
    - queue non-empty: pop the next note and go to LOAD. No silence gap is inserted.
    - queue empty: go to STOP.
  - Note length is exactly max(dur,1)*TICK_DIV cycles, measured from the cycle after drv_ready to the next LOAD.
- STOP: drv_write=1, drv_data=25'h0; go to STOP_ACK.
- STOP_ACK: on drv_ready, pulse done and go to IDLE.
- drv_write is high only in LOAD and STOP, and for exactly one cycle each.
- drv_data holds its last value between writes.
- Queue behaviour:
  - Synchronous FIFO. in_ready = (count != DEPTH).
  - Push and pop in the same cycle: count unchanged. Allowed when the queue is empty only if the push is registered first; the pop is gated by the pre-cycle count, so an empty queue never pops.
  - A push while full is refused (in_ready=0). Pointers wrap modulo DEPTH.
- Abort:
  - In the cycle abort=1, flush the queue (count→0) and drop any simultaneous push.
  - If state is LOAD, ACK or PLAY, go to STOP; the current write, if any, completes.
  - If state is STOP or STOP_ACK, continue as normal.
  - If state is IDLE, abort is a no-op with no done pulse.
- Enqueue during PLAY is legal and extends the melody seamlessly.
- Counters: the tick counter is DUR_W bits and cannot overflow because it compares against duration ≤ 2^DUR_W-1. The prescaler is $clog2(TICK_DIV) bits.

Decomposition:
- Package piezo_pkg holds:
  - state encoding localparams (3-bit);
  - DRV_EN_BIT=24 and PERIOD_W=24;
  - the drv_data silence constant 25'h0.
- One sub-module, piezo_note_fifo:
  - parameterised on DEPTH and on a width of PERIOD_W+DUR_W;
  - synchronous, active-low reset; exposes count, push/pop and head data.

Test Plan (all scenarios use TICK_DIV=10 and a driver model that asserts Ready one cycle after Write):
- Single note: push {period=24'h0003E8, dur=3} from IDLE -> one drv_write with drv_data=25'h10003E8; PLAY lasts 30 cycles; then drv_write with 25'h0000000; done pulses once; busy falls.
- Back-to-back: push 3 notes (dur 1,2,1) -> three LOAD writes spaced 10 and 20 cycles apart after their acks; one STOP write; exactly 4 drv_write pulses total.
- Rest and zero duration: push {period=0, dur=0} -> drv_data=25'h0 written; plays 10 cycles, as if dur=1; then STOP.
- Full queue: hold in_valid for 10 cycles while stalled in ACK (driver Ready withheld), DEPTH=8 -> queue_count saturates at 8 with in_ready=0; exactly 8 entries accepted and played in FIFO order.
- Abort mid-PLAY with 4 queued and in_valid=1 in the same cycle -> queue_count=0 next cycle; push dropped; STOP write follows; done pulses; no further LOAD. Abort in IDLE -> no write, no done.
- Reset mid-PLAY (reset=0 for one cycle) -> next cycle all outputs 0, state IDLE, queue empty; no STOP write is issued.

Source files
------------

// File: rtl/piezo_pkg.sv
// rtl/piezo_pkg.sv - shared types and constants for the piezo tone sequencer
package piezo_pkg;
  localparam int PERIOD_W   = 24;
  localparam int DRV_EN_BIT = 24;
  localparam logic [PERIOD_W:0] DRV_SILENCE = 25'h0;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD     = 3'd1,
    S_ACK      = 3'd2,
    S_PLAY     = 3'd3,
    S_STOP     = 3'd4,
    S_STOP_ACK = 3'd5
  } state_t;

  // A rest (period 0) is written as a fully silent driver word, enable bit included.
  function automatic logic [PERIOD_W:0] drv_word(input logic [PERIOD_W-1:0] period);
    logic [PERIOD_W:0] w;
    w = DRV_SILENCE;
    if (period != '0) begin
      w[DRV_EN_BIT]         = 1'b1;
      w[PERIOD_W-1:0]       = period;
    end
    return w;
  endfunction
endpackage

// File: rtl/piezo_note_fifo.sv
// rtl/piezo_note_fifo.sv - synchronous note queue with flush and occupancy count
module piezo_note_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 40
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [W-1:0]             head,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  // Pop is gated by the pre-cycle count so an empty queue never pops.
  assign do_push = push && (count != CW'(DEPTH)) && !flush;
  assign do_pop  = pop && (count != '0) && !flush;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clock) begin
    if (!reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/piezo_sequencer.sv
// rtl/piezo_sequencer.sv - plays queued notes back-to-back through the piezo driver
module piezo_sequencer
  import piezo_pkg::*;
#(
  parameter int DEPTH    = 8,
  parameter int TICK_DIV = 100000,
  parameter int DUR_W    = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [PERIOD_W-1:0]      in_period,
  input  logic [DUR_W-1:0]         in_duration,
  output logic                     in_ready,
  input  logic                     abort,
  output logic [PERIOD_W:0]        drv_data,
  output logic                     drv_write,
  input  logic                     drv_ready,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   queue_count,
  output logic                     done
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int FW = PERIOD_W + DUR_W;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  state_t              state;
  logic                live;
  logic [DUR_W-1:0]    note_dur;
  logic [DUR_W-1:0]    ticks;
  logic [PW-1:0]       presc;
  logic [FW-1:0]       head;
  logic [CW-1:0]       count;
  logic                push;
  logic                pop;
  logic                note_end;
  logic [DUR_W-1:0]    head_dur;

  assign in_ready    = live && (count != CW'(DEPTH));
  assign push        = in_valid && in_ready && !abort;
  assign queue_count = count;
  assign busy        = (state != S_IDLE);
  assign head_dur    = head[DUR_W-1:0];
  assign note_end    = (presc == PRESC_LAST) && (ticks == note_dur - DUR_W'(1));
  assign pop         = !abort && (count != '0) &&
                       ((state == S_IDLE) || (state == S_PLAY && note_end));

  piezo_note_fifo #(.DEPTH(DEPTH), .W(FW)) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data ({in_period, in_duration}),
    .pop       (pop),
    .flush     (abort),
    .head      (head),
    .count     (count)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      live      <= 1'b0;
      state     <= S_IDLE;
      note_dur  <= '0;
      ticks     <= '0;
      presc     <= '0;
      drv_write <= 1'b0;
      drv_data  <= DRV_SILENCE;
      done      <= 1'b0;
    end else begin
      live      <= 1'b1;
      drv_write <= 1'b0;
      done      <= 1'b0;
      if (pop) begin
        // Next note is loaded straight from the queue head; no silence gap.
        note_dur  <= (head_dur == '0) ? DUR_W'(1) : head_dur;
        drv_data  <= drv_word(head[FW-1:DUR_W]);
        drv_write <= 1'b1;
        state     <= S_LOAD;
      end else begin
        case (state)
          S_IDLE: state <= S_IDLE;
          S_LOAD, S_ACK, S_PLAY: begin
            if (abort || (state == S_PLAY && note_end)) begin
              drv_data  <= DRV_SILENCE;
              drv_write <= 1'b1;
              state     <= S_STOP;
            end else if (state == S_LOAD) begin
              state <= S_ACK;
            end else if (state == S_ACK) begin
              if (drv_ready) begin
                presc <= '0;
                ticks <= '0;
                state <= S_PLAY;
              end
            end else if (presc == PRESC_LAST) begin
              presc <= '0;
              ticks <= ticks + DUR_W'(1);
            end else begin
              presc <= presc + PW'(1);
            end
          end
          S_STOP: state <= S_STOP_ACK;
          S_STOP_ACK: begin
            if (drv_ready) begin
              done  <= 1'b1;
              state <= S_IDLE;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end
endmodule
